mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port word memory between the instruction-fetch path (requester 0) and the load/store path (requester 1). It accepts requests over a valid/ready handshake and drives the memory for a fixed, parameterised access latency. It then returns a one-cycle response to the winning requester. It sits between the PC/fetch logic and the load/store unit on one side and the instruction/data memory array on the other.

---
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between instruction fetch (requester 0)
// and load/store (requester 1) with round-robin arbitration and a fixed access latency.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_we,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_we,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t            state_reg, state_next;
  logic              last_grant_reg, last_grant_next;
  logic              grant_id_reg, grant_id_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              we_reg, we_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] resp_reg, resp_next;

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_rvalid;
  logic              winner;
  logic              handshake;
  logic              respond_active;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;

  assign req_valid = {req1_valid, req0_valid};

  // On a tie the requester that did not win the previous handshake goes first.
  always_comb begin
    winner = 1'b0;
    if (req_valid == 2'b11) begin
      winner = ~last_grant_reg;
    end else if (req_valid[1]) begin
      winner = 1'b1;
    end
  end

  // Readies are held low while reset is asserted so nothing is accepted then.
  assign handshake = (state_reg == ST_IDLE) && reset && (|req_valid);

  assign sel_addr  = winner ? req1_addr  : req0_addr;
  assign sel_we    = winner ? req1_we    : req0_we;
  assign sel_wdata = winner ? req1_wdata : req0_wdata;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      localparam logic ID = 1'(gi);
      assign req_ready[gi]  = handshake && (winner == ID);
      assign req_rvalid[gi] = respond_active && (grant_id_reg == ID);
    end
  endgenerate

  assign req0_ready  = req_ready[0];
  assign req1_ready  = req_ready[1];
  assign req0_rvalid = req_rvalid[0];
  assign req1_rvalid = req_rvalid[1];
  assign req0_rdata  = resp_reg;
  assign req1_rdata  = resp_reg;
  assign grant_id    = grant_id_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= 1'b1;
      grant_id_reg   <= 1'b0;
      cnt_reg        <= 4'd0;
      addr_reg       <= '0;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
      resp_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      grant_id_reg   <= grant_id_next;
      cnt_reg        <= cnt_next;
      addr_reg       <= addr_next;
      we_reg         <= we_next;
      wdata_reg      <= wdata_next;
      resp_reg       <= resp_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (handshake) state_next = ST_ACCESS;
      ST_ACCESS:  if (cnt_reg == 4'd0) state_next = ST_RESPOND;
      ST_RESPOND: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    last_grant_next = last_grant_reg;
    grant_id_next   = grant_id_reg;
    cnt_next        = cnt_reg;
    addr_next       = addr_reg;
    we_next         = we_reg;
    wdata_next      = wdata_reg;
    resp_next       = resp_reg;
    case (state_reg)
      ST_IDLE: begin
        if (handshake) begin
          addr_next       = sel_addr;
          we_next         = sel_we;
          wdata_next      = sel_wdata;
          grant_id_next   = winner;
          last_grant_next = winner;
          cnt_next        = CNT_LOAD;
        end
      end
      ST_ACCESS: begin
        if (cnt_reg == 4'd0) begin
          resp_next = we_reg ? '0 : mem_rdata;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    respond_active = 1'b0;
    busy           = (state_reg != ST_IDLE);
    case (state_reg)
      ST_ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = we_reg;
        mem_addr  = addr_reg;
        mem_wdata = wdata_reg;
      end
      ST_RESPOND: respond_active = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed stimulus for mem_port_arbiter, checked every cycle
// against a transaction-timeline model of the arbiter.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LAT    = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic              req0_we, req1_we;
  logic [DATA_W-1:0] req0_wdata, req1_wdata;
  logic              req0_rvalid, req1_rvalid;
  logic [DATA_W-1:0] req0_rdata, req1_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              busy, grant_id;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_we(req0_we), .req0_wdata(req0_wdata), .req0_rvalid(req0_rvalid),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_we(req1_we), .req1_wdata(req1_wdata), .req1_rvalid(req1_rvalid),
    .req1_rdata(req1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: at most one transaction in flight, handshaken at cycle t_hs.
  bit          act     = 1'b0;
  int          t_hs    = 0;
  bit          own     = 1'b0;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  bit          m_we    = 1'b0;
  bit          m_last  = 1'b1;
  bit          m_grant = 1'b0;
  logic [31:0] m_resp  = '0;
  bit          known   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic [31:0] a,
                         input logic we, input logic [31:0] wd);
    if (id == 0) begin
      req0_valid = v; req0_addr = a; req0_we = we; req0_wdata = wd;
    end else begin
      req1_valid = v; req1_addr = a; req1_we = we; req1_wdata = wd;
    end
  endtask

  // Inputs are already driven; check this cycle's outputs, then advance the model.
  task automatic cycle();
    bit in_acc, in_rsp, w, hs;
    #1;
    in_acc = act && (cyc >= t_hs + 1) && (cyc <= t_hs + LAT);
    in_rsp = act && (cyc == t_hs + LAT + 1);
    w      = (req0_valid && req1_valid) ? !m_last : req1_valid;
    hs     = !act && (reset === 1'b1) && (req0_valid || req1_valid);
    if (known) begin
      check("ready0",    64'(req0_ready),  64'(hs && !w));
      check("ready1",    64'(req1_ready),  64'(hs && w));
      check("mem_en",    64'(mem_en),      64'(in_acc));
      check("mem_we",    64'(mem_we),      64'(in_acc && m_we));
      check("mem_addr",  64'(mem_addr),    64'(in_acc ? m_addr : 32'd0));
      check("mem_wdata", 64'(mem_wdata),   64'(in_acc ? m_wdata : 32'd0));
      check("busy",      64'(busy),        64'(act));
      check("rvalid0",   64'(req0_rvalid), 64'(in_rsp && !own));
      check("rvalid1",   64'(req1_rvalid), 64'(in_rsp && own));
      check("rdata0",    64'(req0_rdata),  64'(m_resp));
      check("rdata1",    64'(req1_rdata),  64'(m_resp));
      check("grant_id",  64'(grant_id),    64'(m_grant));
    end
    @(posedge clk);
    if (reset !== 1'b1) begin
      act = 1'b0; m_last = 1'b1; m_grant = 1'b0; m_resp = '0; known = 1'b1;
    end else begin
      if (in_acc && cyc == t_hs + LAT) m_resp = m_we ? 32'd0 : mem_rdata;
      if (in_rsp) begin
        act = 1'b0;
        $display("txn cycle=%0d req%0d we=%0d addr=%08h wdata=%08h rdata=%08h",
                 cyc, own, m_we, m_addr, m_wdata, m_resp);
      end
      if (hs) begin
        act = 1'b1; t_hs = cyc; own = w; m_last = w; m_grant = w;
        m_addr  = w ? req1_addr  : req0_addr;
        m_we    = w ? req1_we    : req0_we;
        m_wdata = w ? req1_wdata : req0_wdata;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    set_req(0, 1'b0, 32'd0, 1'b0, 32'd0);
    set_req(1, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // Reset held two cycles with both requesters pending.
    reset = 1'b0; mem_rdata = 32'h0BAD_F00D;
    set_req(0, 1'b1, 32'h0000_0040, 1'b0, 32'h1111_1111);
    set_req(1, 1'b1, 32'h0000_0080, 1'b1, 32'h2222_2222);
    cycle(); cycle();
    // Release: continuous contention for four transactions.
    reset = 1'b1;
    for (int i = 0; i < 4 * (LAT + 2); i++) begin
      mem_rdata = $urandom;
      cycle();
    end
    idle_cycles(2);

    // Single read by req1, memory returns a fixed word.
    mem_rdata = 32'hDEAD_BEEF;
    set_req(1, 1'b1, 32'h0000_0010, 1'b0, 32'h0);
    cycle();
    idle_cycles(LAT + 2);

    // Write by req0.
    set_req(0, 1'b1, 32'h0000_0100, 1'b1, 32'h1234_5678);
    cycle();
    idle_cycles(LAT + 2);

    // Reset in the middle of an access, then a tie.
    set_req(1, 1'b1, 32'h0000_0200, 1'b0, 32'h0);
    cycle();
    idle_cycles(1);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    set_req(0, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
    set_req(1, 1'b1, 32'h0000_0304, 1'b0, 32'h0);
    cycle();
    idle_cycles(LAT + 3);

    // req1 raises valid while busy and withdraws it before the arbiter is idle.
    set_req(0, 1'b1, 32'h0000_0400, 1'b0, 32'h0);
    cycle();
    set_req(0, 1'b0, 32'h0, 1'b0, 32'h0);
    set_req(1, 1'b1, 32'h0000_0500, 1'b1, 32'hCAFE_0001);
    cycle(); cycle();
    idle_cycles(LAT + 2);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 39) != 0);
      mem_rdata = $urandom;
      set_req(0, ($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 1)), $urandom);
      set_req(1, ($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 1)), $urandom);
      cycle();
    end
    reset = 1'b1;
    idle_cycles(LAT + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
